// File: rtl/lamp_ramp_driver.sv
// -----------------------------------------------------------------------------
// lamp_ramp_driver
//
// Purpose:
//   Takes the active-lamp count from the active-lamp calculator and turns the
//   room's lamps on or off one at a time, one change every STEP_CYCLES clock
//   edges, so the room brightens and dims smoothly instead of jumping.
//   Reports busy while a ramp is in progress and pulses done for one cycle
//   when the lit-lamp count reaches the target (or a no-op target arrives).
//
// Parameters:
//   STEP_CYCLES    clock edges between successive lamp changes (1..255)
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous, active-high reset
//   active_lights  [3:0]  requested lamp count 0..15
//   target_valid   one-cycle strobe, samples active_lights as the new target
//   lamps          [14:0] thermometer lamp enables, bit i = lamp i on
//   lamp_count     [3:0]  number of lamps currently on (popcount of lamps)
//   busy           high while ramping up or down
//   done           one-cycle pulse when a ramp completes or a no-op target
//                  is accepted
//
// Optional feature:
//   LAMP_INSTANT_OFF_EN  when defined, a target of 0 switches every lamp off
//                        at the strobe edge instead of ramping down.
// -----------------------------------------------------------------------------
module lamp_ramp_driver #(
   parameter int unsigned STEP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  active_lights,
   input  logic        target_valid,
   output logic [14:0] lamps,
   output logic [3:0]  lamp_count,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] RELOAD = 8'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  target_reg, target_nxt;
   logic [3:0]  count, count_nxt;
   logic [7:0]  prescaler, prescaler_nxt;
   logic        done_nxt;
   logic        ramping;
   logic        tick;
   logic        instant_off;

   // Thermometer decode: lamp i is lit when i is below the lit-lamp count.
   function automatic logic [14:0] therm_decode(input logic [3:0] n);
      logic [14:0] t;
      t = '0;
      for (int i = 0; i < 15; i++) begin
         t[i] = (i < int'(n));
      end
      return t;
   endfunction

   // One lamp step in the given direction, pinned at 0 and 15. The FSM only
   // moves toward a target on the far side of count, so the pins never
   // engage in normal operation; they just keep count from wrapping.
   function automatic logic [3:0] step_count(input logic [3:0] n,
                                             input logic       up);
      logic [3:0] r;
      if (up) begin
         r = (n == 4'hF) ? n : n + 4'd1;
      end else begin
         r = (n == 4'h0) ? n : n - 4'd1;
      end
      return r;
   endfunction

   assign ramping = (state != IDLE);
   assign tick    = ramping && (prescaler == 8'd0);

`ifdef LAMP_INSTANT_OFF_EN
   assign instant_off = target_valid && (active_lights == 4'd0);
`else
   assign instant_off = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and datapath decisions. A target strobe always takes
   // priority over a step tick on the same edge: the tick is dropped and
   // the new target picks the direction.
   always_comb begin
      state_nxt     = state;
      target_nxt    = target_reg;
      count_nxt     = count;
      prescaler_nxt = prescaler;
      done_nxt      = 1'b0;

      if (instant_off) begin
         target_nxt    = 4'd0;
         count_nxt     = 4'd0;
         prescaler_nxt = RELOAD;
         state_nxt     = IDLE;
         done_nxt      = 1'b1;
      end else if (target_valid) begin
         target_nxt = active_lights;
         if (active_lights > count) begin
            state_nxt = UP;
         end else if (active_lights < count) begin
            state_nxt = DOWN;
         end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         // A fresh ramp starts a full step interval; a retarget mid-ramp
         // keeps the current interval running unless it just expired.
         if (!ramping || tick) begin
            prescaler_nxt = RELOAD;
         end else begin
            prescaler_nxt = prescaler - 8'd1;
         end
      end else if (ramping) begin
         if (tick) begin
            count_nxt     = step_count(count, state == UP);
            prescaler_nxt = RELOAD;
            if (count_nxt == target_reg) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end else begin
            prescaler_nxt = prescaler - 8'd1;
         end
      end
   end

   // Datapath registers; count is cleared asynchronously so lamps drop
   // the moment reset asserts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_reg <= 4'd0;
         count      <= 4'd0;
         prescaler  <= 8'd0;
         done       <= 1'b0;
      end else begin
         target_reg <= target_nxt;
         count      <= count_nxt;
         prescaler  <= prescaler_nxt;
         done       <= done_nxt;
      end
   end

   assign lamps      = therm_decode(count);
   assign lamp_count = count;
   assign busy       = ramping;

endmodule

// File: tb/tb_lamp_ramp_driver.sv
// -----------------------------------------------------------------------------
// tb_lamp_ramp_driver
//
// Self-checking bench for lamp_ramp_driver with STEP_CYCLES = 4. Each test
// task drives a target strobe and pushes the expected outputs for every
// following clock edge into a queue; a monitor on the falling edge pops one
// entry per edge and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_lamp_ramp_driver;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  active_lights = 4'd0;
   logic        target_valid  = 1'b0;
   logic [14:0] lamps;
   logic [3:0]  lamp_count;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lamp_ramp_driver #(.STEP_CYCLES(S)) dut (
      .clk          (clk),
      .rst          (rst),
      .active_lights(active_lights),
      .target_valid (target_valid),
      .lamps        (lamps),
      .lamp_count   (lamp_count),
      .busy         (busy),
      .done         (done)
   );

   typedef struct {
      logic [14:0] lamps;
      logic [3:0]  cnt;
      logic        busy;
      logic        done;
      string       tag;
      int          edge_n;
   } exp_t;

   exp_t sb[$];
   exp_t mx;

   // Expected lamp vector: the lowest c bits set.
   function automatic logic [14:0] therm(input int c);
      logic [14:0] full;
      full = 15'h7FFF;
      return full >> (15 - c);
   endfunction

   task automatic push_exp(input int c, input logic b, input logic d,
                           input string tag, input int e);
      exp_t x;
      x.lamps  = therm(c);
      x.cnt    = 4'(c);
      x.busy   = b;
      x.done   = d;
      x.tag    = tag;
      x.edge_n = e;
      sb.push_back(x);
   endtask

   // Monitor: one expected entry per rising edge, sampled mid-cycle.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mx = sb.pop_front();
         total++;
         if (lamps !== mx.lamps) begin
            bad++;
            $display("FAIL %s edge %0d lamps: got %h want %h", mx.tag, mx.edge_n, lamps, mx.lamps);
         end
         total++;
         if (lamp_count !== mx.cnt) begin
            bad++;
            $display("FAIL %s edge %0d lamp_count: got %0d want %0d", mx.tag, mx.edge_n, lamp_count, mx.cnt);
         end
         total++;
         if (busy !== mx.busy) begin
            bad++;
            $display("FAIL %s edge %0d busy: got %b want %b", mx.tag, mx.edge_n, busy, mx.busy);
         end
         total++;
         if (done !== mx.done) begin
            bad++;
            $display("FAIL %s edge %0d done: got %b want %b", mx.tag, mx.edge_n, done, mx.done);
         end
      end
   end

   // Strobe target t at the next edge (edge 0) from a settled count c0 and
   // expect n edges of a plain ramp: one lamp per S edges, busy until the
   // last change, done on exactly that edge (edge 0 for a no-op target).
   // Called just after a falling edge; returns just after a falling edge.
   task automatic run_ramp(input int c0, input int t, input int n, input string tag);
      int d, ad, st, c;
      active_lights = 4'(t);
      target_valid  = 1'b1;
      d  = t - c0;
      ad = (d < 0) ? -d : d;
      for (int k = 0; k < n; k++) begin
         st = k / S;
         if (st > ad) st = ad;
         c = (d > 0) ? c0 + st : c0 - st;
         push_exp(c, (k < ad * S), (k == ad * S), tag, k);
      end
      for (int k = 0; k < n; k++) begin
         @(negedge clk); #1;
         target_valid = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (lamps !== 15'h0000) begin
         bad++;
         $display("FAIL reset lamps: got %h want 0000", lamps);
      end
      total++;
      if (lamp_count !== 4'd0) begin
         bad++;
         $display("FAIL reset lamp_count: got %0d want 0", lamp_count);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset busy: got %b want 0", busy);
      end
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL reset done: got %b want 0", done);
      end
      #1;
      rst = 1'b0;
      for (int k = 0; k < 20; k++) push_exp(0, 1'b0, 1'b0, "idle_hold", k);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic test_ramp_up;
      run_ramp(0, 3, 14, "ramp_up3");
   endtask

   // From 3: target 5 at edge 0, retarget 1 at edge 5. The retarget does
   // not restart the step interval, so changes land on edges 8/12/16.
   task automatic test_reversal;
      int c;
      active_lights = 4'd5;
      target_valid  = 1'b1;
      for (int k = 0; k < 18; k++) begin
         if (k < 4)       c = 3;
         else if (k < 8)  c = 4;
         else if (k < 12) c = 3;
         else if (k < 16) c = 2;
         else             c = 1;
         push_exp(c, (k < 16), (k == 16), "reversal", k);
      end
      for (int k = 0; k < 18; k++) begin
         @(negedge clk); #1;
         if (k == 4) begin
            active_lights = 4'd1;
            target_valid  = 1'b1;
         end else begin
            target_valid = 1'b0;
         end
      end
   endtask

   // From 1: target 5 at edge 0, then target 3 exactly on the edge-4 tick.
   // The tick is dropped and the interval restarts from the new strobe.
   task automatic test_coincident;
      run_ramp(1, 5, 4, "coin_pre");
      run_ramp(1, 3, 10, "coin_tick");
   endtask

   task automatic test_async_reset;
      run_ramp(3, 1, 6, "rst_pre");
      total++;
      if (lamp_count !== 4'd2 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rst_setup: got count %0d busy %b want count 2 busy 1", lamp_count, busy);
      end
      rst = 1'b1;
      #1;
      total++;
      if (lamps !== 15'h0000) begin
         bad++;
         $display("FAIL rst_async lamps: got %h want 0000", lamps);
      end
      total++;
      if (lamp_count !== 4'd0) begin
         bad++;
         $display("FAIL rst_async lamp_count: got %0d want 0", lamp_count);
      end
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL rst_async busy/done: got %b/%b want 0/0", busy, done);
      end
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) push_exp(0, 1'b0, 1'b0, "rst_idle", k);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic test_full_and_noop;
      run_ramp(0, 15, 62, "full15");
      run_ramp(15, 15, 3, "noop15");
   endtask

   task automatic test_off;
      run_ramp(15, 6, 37, "down6");
`ifdef LAMP_INSTANT_OFF_EN
      active_lights = 4'd0;
      target_valid  = 1'b1;
      push_exp(0, 1'b0, 1'b1, "instant_off", 0);
      push_exp(0, 1'b0, 1'b0, "instant_off", 1);
      push_exp(0, 1'b0, 1'b0, "instant_off", 2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         target_valid = 1'b0;
      end
`else
      run_ramp(6, 0, 26, "ramp_off");
`endif
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_reversal();
      test_coincident();
      test_async_reset();
      test_full_and_noop();
      test_off();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
